// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, data width, bit-period helper.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd1,
    S_START    = 3'd2,
    S_REC_BYTE = 3'd3,
    S_STOP     = 3'd4,
    S_DATA     = 3'd5
  } uart_state_t;

  // Clocks per bit; integer division, so the bit period rounds down.
  function automatic int calc_cycle(input int clk_fre, input int baud_rate);
    return (clk_fre * 1000000) / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the async rx line plus a history flop for falling-edge detect.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_pin,
  output logic rx_level,
  output logic rx_negedge
);

  logic r_rx_d0;
  logic r_rx_d1;
  logic r_rx_d2;

  // Reset to 1 so an idle-high line never looks like a start edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_d0 <= 1'b1;
      r_rx_d1 <= 1'b1;
      r_rx_d2 <= 1'b1;
    end else begin
      r_rx_d0 <= rx_pin;
      r_rx_d1 <= r_rx_d0;
      r_rx_d2 <= r_rx_d1;
    end
  end

  assign rx_level   = r_rx_d1;
  assign rx_negedge = r_rx_d2 & ~r_rx_d1;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling; byte delivered by valid/ready.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_pin,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_data_valid,
  input  logic              rx_data_ready,
  output logic              rx_frame_err
);

  localparam int          CYCLE    = calc_cycle(CLK_FRE, BAUD_RATE);
  localparam logic [15:0] HALF_END = 16'(CYCLE / 2 - 1);
  localparam logic [15:0] CYC_END  = 16'(CYCLE - 1);

  uart_state_t       r_state;
  uart_state_t       w_next_state;
  logic [15:0]       r_cycle_cnt;
  logic [2:0]        r_bit_cnt;
  logic [DATA_W-1:0] r_rx_bits;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_frame_err;
  logic              w_rx_level;
  logic              w_rx_negedge;
  logic              w_mid;
  logic              w_end;
  logic              w_load;
  logic              w_stop_err;

  uart_rx_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_pin     (rx_pin),
    .rx_level   (w_rx_level),
    .rx_negedge (w_rx_negedge)
  );

  assign w_mid = (r_cycle_cnt == HALF_END);
  assign w_end = (r_cycle_cnt == CYC_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (w_rx_negedge) w_next_state = S_START;
      S_START: begin
        // A start bit that is high again at its midpoint was only a glitch.
        if (w_mid && w_rx_level) w_next_state = S_IDLE;
        else if (w_end)          w_next_state = S_REC_BYTE;
      end
      S_REC_BYTE: if (w_end && r_bit_cnt == 3'd7) w_next_state = S_STOP;
      S_STOP:     if (w_mid) w_next_state = w_rx_level ? S_DATA : S_IDLE;
      S_DATA:     if (rx_data_ready) w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    rx_data_valid = (r_state == S_DATA);
    w_load        = (r_state == S_STOP) && w_mid && w_rx_level;
    w_stop_err    = (r_state == S_STOP) && w_mid && !w_rx_level;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt <= 16'd0;
      r_bit_cnt   <= 3'd0;
      r_rx_bits   <= '0;
      r_rx_data   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      if ((r_state != w_next_state) || (r_state == S_REC_BYTE && w_end))
        r_cycle_cnt <= 16'd0;
      else
        r_cycle_cnt <= r_cycle_cnt + 16'd1;

      if (r_state != S_REC_BYTE) r_bit_cnt <= 3'd0;
      else if (w_end)            r_bit_cnt <= r_bit_cnt + 3'd1;

      if (r_state == S_REC_BYTE && w_mid) r_rx_bits[r_bit_cnt] <= w_rx_level;
      if (w_load) r_rx_data <= r_rx_bits;
      // Registered so the error pulse lands on the same cycle valid would rise.
      r_frame_err <= w_stop_err;
    end
  end

  assign rx_data      = r_rx_data;
  assign rx_frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames, corner sequences, random frames.
module tb_uart_rx;

  localparam int CLK_FRE   = 50;
  localparam int BAUD_RATE = 115200;
  localparam int CYC       = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int HALF      = CYC / 2;
  localparam int LAT_LO    = 4125;
  localparam int LAT_HI    = 4127;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_pin = 1'b1;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready = 1'b1;
  logic       rx_frame_err;

  uart_rx #(.CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD_RATE)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_pin        (rx_pin),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .rx_frame_err  (rx_frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor state, sampled on the falling edge.
  logic [7:0] got_q[$];
  int         rise_cyc = 0;
  int         err_cyc = 0;
  int         err_cycles = 0;
  int         stab_viol = 0;
  int         vlen = 0;
  int         last_vlen = 0;
  int         fall_cyc = 0;
  logic       prev_valid = 1'b0;
  logic       prev_err = 1'b0;
  logic [7:0] hold_data = 8'h00;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_err   = 1'b0;
      vlen       = 0;
    end else begin
      if (rx_data_valid) begin
        if (!prev_valid) begin
          rise_cyc  = cyc;
          hold_data = rx_data;
          vlen      = 0;
        end else if (rx_data !== hold_data) begin
          stab_viol++;
        end
        vlen++;
        if (rx_data_ready) got_q.push_back(rx_data);
      end else if (prev_valid) begin
        last_vlen = vlen;
      end
      if (rx_frame_err) begin
        err_cycles++;
        if (!prev_err) err_cyc = cyc;
      end
      prev_valid = rx_data_valid;
      prev_err   = rx_frame_err;
    end
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives start bit, 8 data bits LSB first, and the given stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx_pin   = 1'b0;
    fall_cyc = cyc;
    wait_clk(CYC);
    for (int i = 0; i < 8; i++) begin
      rx_pin = d[i];
      wait_clk(CYC);
    end
    rx_pin = stop;
    wait_clk(CYC);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         ready_lo;
    int         gap;
    logic       exp_valid;
    logic       exp_err;
  } vec_t;

  logic [7:0] last_good = 8'h00;

  task automatic run_vec(input vec_t v);
    int q0;
    int e0;
    q0 = got_q.size();
    e0 = err_cycles;
    last_vlen = 0;
    rx_data_ready = (v.ready_lo == 0);
    send_frame(v.data, v.stop);
    if (v.exp_valid) begin
      if (v.ready_lo > 0) begin
        chk("held_valid_start", rx_data_valid, 1'b1);
        wait_clk(v.ready_lo);
        chk("held_valid_end", rx_data_valid, 1'b1);
        chk("held_data", rx_data, v.data);
        rx_data_ready = 1'b1;
        wait_clk(1);
        chk("valid_drop_after_ready", rx_data_valid, 1'b0);
      end else begin
        chk("valid_len", last_vlen, 1);
      end
      chk_rng("valid_latency", rise_cyc - fall_cyc, LAT_LO, LAT_HI);
      chk("bytes_delivered", got_q.size() - q0, 1);
      if (got_q.size() > q0) chk("byte_value", got_q[q0], v.data);
      last_good = v.data;
    end else begin
      chk("no_byte", got_q.size() - q0, 0);
      chk_rng("err_latency", err_cyc - fall_cyc, LAT_LO, LAT_HI);
    end
    chk("err_cycles", err_cycles - e0, v.exp_err ? 1 : 0);
    chk("rx_data_model", rx_data, last_good);
    rx_pin = 1'b1;
    if (v.gap > 0) wait_clk(v.gap);
  endtask

  vec_t vecs[6];

  initial begin
    int q0;
    int e0;
    vec_t rv;

    vecs[0] = '{data: 8'h55, stop: 1'b1, ready_lo: 0,    gap: 20, exp_valid: 1'b1, exp_err: 1'b0};
    vecs[1] = '{data: 8'hA3, stop: 1'b0, ready_lo: 0,    gap: 20, exp_valid: 1'b0, exp_err: 1'b1};
    vecs[2] = '{data: 8'h12, stop: 1'b1, ready_lo: 0,    gap: 20, exp_valid: 1'b1, exp_err: 1'b0};
    vecs[3] = '{data: 8'hC9, stop: 1'b1, ready_lo: 1000, gap: 20, exp_valid: 1'b1, exp_err: 1'b0};
    vecs[4] = '{data: 8'h00, stop: 1'b1, ready_lo: 0,    gap: 0,  exp_valid: 1'b1, exp_err: 1'b0};
    vecs[5] = '{data: 8'hFF, stop: 1'b1, ready_lo: 0,    gap: 20, exp_valid: 1'b1, exp_err: 1'b0};

    wait_clk(3);
    chk("reset_data", rx_data, 8'h00);
    chk("reset_valid", rx_data_valid, 1'b0);
    chk("reset_err", rx_frame_err, 1'b0);
    rst_n = 1'b1;
    wait_clk(10);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Short low glitch must be rejected and leave the receiver idle.
    q0 = got_q.size();
    e0 = err_cycles;
    rx_pin = 1'b0;
    wait_clk(100);
    rx_pin = 1'b1;
    wait_clk(1000);
    chk("glitch_no_byte", got_q.size() - q0, 0);
    chk("glitch_no_err", err_cycles - e0, 0);
    chk("glitch_valid_low", rx_data_valid, 1'b0);

    // Reset during data bit 3 of 0x7E.
    rx_pin = 1'b0;
    wait_clk(CYC);
    for (int i = 0; i < 3; i++) begin
      rx_pin = vecs[0].data[i] ^ vecs[0].data[i] ^ ((8'h7E >> i) & 8'h01) ? 1'b1 : 1'b0;
      wait_clk(CYC);
    end
    rx_pin = 1'b1;
    wait_clk(HALF);
    rst_n = 1'b0;
    #1;
    chk("midreset_data", rx_data, 8'h00);
    chk("midreset_valid", rx_data_valid, 1'b0);
    chk("midreset_err", rx_frame_err, 1'b0);
    last_good = 8'h00;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(50);
    chk("postreset_data", rx_data, 8'h00);
    rv = '{data: 8'h3C, stop: 1'b1, ready_lo: 0, gap: 20, exp_valid: 1'b1, exp_err: 1'b0};
    run_vec(rv);

    // Random frames; expected outcome follows directly from the stop bit.
    for (int i = 0; i < 6; i++) begin
      rv.data      = 8'($urandom_range(0, 255));
      rv.stop      = ($urandom_range(0, 3) != 0);
      rv.ready_lo  = 0;
      rv.gap       = rv.stop ? int'($urandom_range(0, 40)) : int'($urandom_range(5, 40));
      rv.exp_valid = rv.stop;
      rv.exp_err   = !rv.stop;
      run_vec(rv);
    end

    chk("data_stable_while_valid", stab_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
